// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp and a registered
// compare output, accessed through a single-cycle request / next-cycle ack register bus.
module machine_timer #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        err,
   output logic        time_compare
);

   localparam int unsigned   PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

   localparam logic [2:0] REG_MTIME_LO = 3'd0;
   localparam logic [2:0] REG_MTIME_HI = 3'd1;
   localparam logic [2:0] REG_CMP_LO   = 3'd2;
   localparam logic [2:0] REG_CMP_HI   = 3'd3;
   localparam logic [2:0] REG_CTRL     = 3'd4;

   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;
   logic          en_q, en_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [31:0]   hi_shadow_q, hi_shadow_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          ack_q, err_q, err_d;
   logic          tc_q;

   logic       tick;
   logic [2:0] reg_idx;
   logic       addr_ok;
   logic       wr;
   logic       rd;

   assign reg_idx = addr[4:2];
   assign addr_ok = (addr[1:0] == 2'b00) && (reg_idx <= REG_CTRL);
   assign wr      = req && we && addr_ok;
   assign rd      = req && !we && addr_ok;

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      tick   = en_q && (pcnt_q == PCNT_LAST);
      pcnt_d = '0;
      if (en_q && !tick) begin
         pcnt_d = pcnt_q + PW'(1);
      end

      // A bus write to either mtime half replaces the incremented value, dropping the tick.
      mtime_d     = mtime_q + {63'd0, tick};
      mtimecmp_d  = mtimecmp_q;
      en_d        = en_q;
      hi_shadow_d = hi_shadow_q;
      rdata_d     = '0;
      err_d       = req && !addr_ok;

      if (wr) begin
         case (reg_idx)
            REG_MTIME_LO: mtime_d    = {mtime_q[63:32], wdata};
            REG_MTIME_HI: mtime_d    = {wdata, mtime_q[31:0]};
            REG_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], wdata};
            REG_CMP_HI:   mtimecmp_d = {wdata, mtimecmp_q[31:0]};
            REG_CTRL:     en_d       = wdata[0];
            default:      ;
         endcase
      end

      if (rd) begin
         case (reg_idx)
            REG_MTIME_LO: begin
               rdata_d     = mtime_q[31:0];
               hi_shadow_d = mtime_q[63:32];
            end
            REG_MTIME_HI: rdata_d = hi_shadow_q;
            REG_CMP_LO:   rdata_d = mtimecmp_q[31:0];
            REG_CMP_HI:   rdata_d = mtimecmp_q[63:32];
            REG_CTRL:     rdata_d = {31'd0, en_q};
            default:      rdata_d = '0;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values and simulation matches the synthesized hardware.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         mtime_q     <= '0;
         mtimecmp_q  <= '1;
         en_q        <= 1'b1;
         pcnt_q      <= '0;
         hi_shadow_q <= '0;
         rdata_q     <= '0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         tc_q        <= 1'b0;
      end else begin
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         en_q        <= en_d;
         pcnt_q      <= pcnt_d;
         hi_shadow_q <= hi_shadow_d;
         rdata_q     <= rdata_d;
         ack_q       <= req;
         err_q       <= err_d;
         tc_q        <= (mtime_q >= mtimecmp_q);
      end
   end

   assign rdata        = rdata_q;
   assign ack          = ack_q;
   assign err          = err_q;
   assign time_compare = tc_q;

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: two instances (PRESCALE 1 and 4) share the bus,
// a reference model predicts responses into scoreboards that a monitor drains on ack.
module tb_machine_timer;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        chk;
   } rsp_t;

   logic        clk    = 1'b0;
   logic        resetn = 1'b0;
   logic        req    = 1'b0;
   logic        we     = 1'b0;
   logic [4:0]  addr   = '0;
   logic [31:0] wdata  = '0;

   logic [31:0] rdata1, rdata4;
   logic        ack1, ack4, err1, err4, tc1, tc4;

   machine_timer #(.PRESCALE(1)) u_p1 (
      .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata1), .ack(ack1), .err(err1), .time_compare(tc1)
   );

   machine_timer #(.PRESCALE(4)) u_p4 (
      .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata4), .ack(ack4), .err(err4), .time_compare(tc4)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int          pre [2] = '{1, 4};
   logic [63:0] m_mt [2];
   logic [63:0] m_cmp [2];
   logic        m_en [2];
   int          m_pc [2];
   logic [31:0] m_sh [2];
   logic        m_tc [2];
   rsp_t        sb0 [$];
   rsp_t        sb1 [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one step per rising edge, using the bus inputs seen at that edge.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         rsp_t        r;
         logic [63:0] nxt;
         logic        ok;
         logic        tick;
         if (!resetn) begin
            m_mt[i]  = 64'd0;
            m_cmp[i] = {64{1'b1}};
            m_en[i]  = 1'b1;
            m_pc[i]  = 0;
            m_sh[i]  = 32'd0;
            m_tc[i]  = 1'b0;
            if (i == 0) sb0.delete(); else sb1.delete();
         end else begin
            m_tc[i] = (m_mt[i] >= m_cmp[i]);
            tick    = m_en[i] && (m_pc[i] == pre[i] - 1);
            m_pc[i] = !m_en[i] ? 0 : (tick ? 0 : m_pc[i] + 1);
            nxt     = m_mt[i] + (tick ? 64'd1 : 64'd0);
            if (req) begin
               ok      = (addr % 4 == 0) && (addr <= 5'h10);
               r.err   = !ok;
               r.rdata = 32'd0;
               r.chk   = !(ok && we);
               if (ok && !we) begin
                  case (addr)
                     5'h00: begin r.rdata = m_mt[i][31:0]; m_sh[i] = m_mt[i][63:32]; end
                     5'h04: r.rdata = m_sh[i];
                     5'h08: r.rdata = m_cmp[i][31:0];
                     5'h0C: r.rdata = m_cmp[i][63:32];
                     default: r.rdata = {31'd0, m_en[i]};
                  endcase
               end
               if (ok && we) begin
                  case (addr)
                     5'h00: nxt = {m_mt[i][63:32], wdata};
                     5'h04: nxt = {wdata, m_mt[i][31:0]};
                     5'h08: m_cmp[i] = {m_cmp[i][63:32], wdata};
                     5'h0C: m_cmp[i] = {wdata, m_cmp[i][31:0]};
                     default: m_en[i] = wdata[0];
                  endcase
               end
               if (i == 0) sb0.push_back(r); else sb1.push_back(r);
            end
            m_mt[i] = nxt;
         end
      end
   endtask

   task automatic mon_port(input int i, input logic a, input logic e, input logic [31:0] d,
                           input logic t);
      rsp_t  r;
      int    n;
      string p;
      p = (i == 0) ? "p1" : "p4";
      n = (i == 0) ? sb0.size() : sb1.size();
      if (n == 0) begin
         check({p, "_spurious_ack"}, {63'd0, a}, 64'd0);
         check({p, "_idle_rdata"}, {32'd0, d}, 64'd0);
         check({p, "_idle_err"}, {63'd0, e}, 64'd0);
      end else begin
         r = (i == 0) ? sb0.pop_front() : sb1.pop_front();
         check({p, "_ack"}, {63'd0, a}, 64'd1);
         check({p, "_err"}, {63'd0, e}, {63'd0, r.err});
         if (r.chk) check({p, "_rdata"}, {32'd0, d}, {32'd0, r.rdata});
      end
      check({p, "_time_compare"}, {63'd0, t}, {63'd0, m_tc[i]});
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      mon_port(0, ack1, err1, rdata1, tc1);
      mon_port(1, ack4, err4, rdata4, tc4);
   end

   task automatic access(input logic w, input logic [4:0] a, input logic [31:0] d);
      req   = 1'b1;
      we    = w;
      addr  = a;
      wdata = d;
      @(negedge clk);
      req   = 1'b0;
      we    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      idle(2);
      resetn = 1'b1;
   endtask

   initial begin
      logic [4:0]  a;
      logic [31:0] d;
      logic        w;
      @(negedge clk);
      do_reset();

      // Reset values of mtimecmp and CTRL.
      access(1'b0, 5'h0C, 32'd0);
      access(1'b0, 5'h10, 32'd0);
      idle(2);

      // Prescaled counting, then frozen by en=0.
      do_reset();
      idle(40);
      access(1'b0, 5'h00, 32'd0);
      access(1'b1, 5'h10, 32'd0);
      idle(20);
      access(1'b0, 5'h00, 32'd0);
      access(1'b0, 5'h04, 32'd0);

      // Compare rises when mtime reaches 20, falls after CMP_LO=FFFFFFFF.
      do_reset();
      access(1'b1, 5'h0C, 32'd0);
      access(1'b1, 5'h08, 32'd20);
      idle(30);
      access(1'b1, 5'h08, 32'hFFFF_FFFF);
      idle(3);

      // Carry from LO into HI; write beats tick.
      access(1'b1, 5'h04, 32'd0);
      access(1'b1, 5'h00, 32'hFFFF_FFFE);
      idle(2);
      access(1'b0, 5'h00, 32'd0);
      access(1'b0, 5'h04, 32'd0);
      access(1'b1, 5'h00, 32'h0000_1234);
      access(1'b0, 5'h00, 32'd0);

      // Atomic LO-then-HI read across a carry.
      access(1'b1, 5'h04, 32'd1);
      access(1'b1, 5'h00, 32'hFFFF_FFFF);
      access(1'b0, 5'h00, 32'd0);
      idle(2);
      access(1'b0, 5'h04, 32'd0);

      // Misaligned / unmapped accesses, then confirm registers are untouched.
      access(1'b0, 5'h02, 32'd0);
      access(1'b1, 5'h14, 32'hDEAD_BEEF);
      access(1'b1, 5'h0A, 32'h0000_0000);
      access(1'b1, 5'h11, 32'h0000_0000);
      access(1'b0, 5'h08, 32'd0);
      access(1'b0, 5'h0C, 32'd0);
      access(1'b0, 5'h10, 32'd0);

      // Reset coinciding with a request: no ack may follow.
      req    = 1'b1;
      we     = 1'b0;
      addr   = 5'h08;
      resetn = 1'b0;
      @(negedge clk);
      req    = 1'b0;
      resetn = 1'b1;
      idle(3);

      // Randomized traffic, biased towards compare crossings and live registers.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(3) == 0) begin
            idle(1);
         end else begin
            w = ($urandom_range(1) == 1);
            case ($urandom_range(9))
               0, 1:    a = 5'h00;
               2:       a = 5'h04;
               3, 4:    a = 5'h08;
               5:       a = 5'h0C;
               6:       a = 5'h10;
               7:       a = 5'($urandom);
               default: a = 5'h08;
            endcase
            case (a)
               5'h00:   d = $urandom_range(15) == 0 ? 32'hFFFF_FFF0 + $urandom_range(15)
                                                    : $urandom;
               5'h04:   d = $urandom_range(7) == 0 ? $urandom : m_mt[0][63:32];
               5'h08:   d = m_mt[0][31:0] + 32'($urandom_range(12)) - 32'd4;
               5'h0C:   d = $urandom_range(7) == 0 ? m_mt[0][63:32] + 32'd1 : m_mt[0][63:32];
               5'h10:   d = ($urandom_range(4) == 0) ? 32'd0 : 32'hFFFF_FFFF;
               default: d = $urandom;
            endcase
            access(w, a, d);
         end
      end
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
